// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants and helpers for the single-cycle RISC-V core datapath.
//   XLEN              : architectural register width
//   F3_B/H/W/BU/HU    : funct3 encodings for RV32I loads and stores
//   sext_byte/half    : sign-extension helpers
//   zext_byte/half    : zero-extension helpers
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A signed operand in a wider assignment context replicates its MSB.
  function automatic logic [XLEN-1:0] sext_byte(input logic [7:0] b);
    logic signed [7:0]      b_s;
    logic signed [XLEN-1:0] w_s;
    b_s = b;
    w_s = XLEN'(b_s);
    return w_s;
  endfunction

  function automatic logic [XLEN-1:0] sext_half(input logic [15:0] h);
    logic signed [15:0]     h_s;
    logic signed [XLEN-1:0] w_s;
    h_s = h;
    w_s = XLEN'(h_s);
    return w_s;
  endfunction

  function automatic logic [XLEN-1:0] zext_byte(input logic [7:0] b);
    return {{(XLEN-8){1'b0}}, b};
  endfunction

  function automatic logic [XLEN-1:0] zext_half(input logic [15:0] h);
    return {{(XLEN-16){1'b0}}, h};
  endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Formats the four raw bytes read at a..a+3 into an RV32I load result.
//   funct3_i : load type (LB/LH/LW/LBU/LHU); other codes yield 0
//   byte0_i  : byte at a   (least significant)
//   byte1_i  : byte at a+1
//   byte2_i  : byte at a+2
//   byte3_i  : byte at a+3 (most significant)
//   data_o   : sign- or zero-extended load value
// -----------------------------------------------------------------------------
module load_extend
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [7:0]      byte0_i,
  input  logic [7:0]      byte1_i,
  input  logic [7:0]      byte2_i,
  input  logic [7:0]      byte3_i,
  output logic [XLEN-1:0] data_o
);

  logic [15:0] half;
  logic [31:0] word;

  assign half = {byte1_i, byte0_i};
  assign word = {byte3_i, byte2_i, byte1_i, byte0_i};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = sext_byte(byte0_i);
      F3_H:    data_o = sext_half(half);
      F3_W:    data_o = word;
      F3_BU:   data_o = zext_byte(byte0_i);
      F3_HU:   data_o = zext_half(half);
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Byte-addressable, little-endian data memory for the MEM stage of the
// single-cycle core. Stores commit on the rising clock edge; loads are
// combinational. Multi-byte accesses wrap modulo the memory depth and
// need not be aligned.
//   clk           : clock
//   rst           : asynchronous active-high reset, clears every byte
//   mem_read      : load enable; output is 0 when low
//   mem_write     : store enable
//   rs2_data      : store data (low bits for SB/SH)
//   alu_result    : effective byte address (upper bits ignored)
//   instruction   : current instruction, funct3 = instruction[14:12]
//   data_mem_data : extended load result
// -----------------------------------------------------------------------------
module data_memory
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] data_mem_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0]            mem_q [DEPTH];
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH-1:0] byte_addr [4];
  logic [3:0]            wr_be_d;
  logic [7:0]            wr_byte_d [4];
  logic [7:0]            rd_byte [4];
  logic [XLEN-1:0]       load_val;

  // Bits outside the address range and the rest of the instruction word
  // are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{alu_result[XLEN-1:ADDR_WIDTH],
                         instruction[31:15], instruction[11:0]};

  assign funct3    = instruction[14:12];
  assign base_addr = alu_result[ADDR_WIDTH-1:0];

  // Natural overflow of the ADDR_WIDTH-bit sum gives the wrap at the top.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = base_addr + ADDR_WIDTH'(k);
    end
  end

  // Byte enables and data lanes for the store.
  always_comb begin
    wr_be_d = 4'b0000;
    if (mem_write) begin
      case (funct3)
        F3_B:    wr_be_d = 4'b0001;
        F3_H:    wr_be_d = 4'b0011;
        F3_W:    wr_be_d = 4'b1111;
        default: wr_be_d = 4'b0000;
      endcase
    end
    for (int k = 0; k < 4; k++) begin
      wr_byte_d[k] = rs2_data[8*k +: 8];
    end
  end

  // Reset clears the whole array asynchronously and masks any store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be_d[k]) begin
          mem_q[byte_addr[k]] <= wr_byte_d[k];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_byte[k] = mem_q[byte_addr[k]];
    end
  end

  load_extend u_load_extend (
    .funct3_i (funct3),
    .byte0_i  (rd_byte[0]),
    .byte1_i  (rd_byte[1]),
    .byte2_i  (rd_byte[2]),
    .byte3_i  (rd_byte[3]),
    .data_o   (load_val)
  );

  assign data_mem_data = mem_read ? load_val : '0;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] rs2_data;
  logic [31:0] alu_result;
  logic [31:0] instruction;
  logic [31:0] data_mem_data;

  int checks = 0;
  int errors = 0;

  data_memory #(.ADDR_WIDTH(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .rs2_data      (rs2_data),
    .alu_result    (alu_result),
    .instruction   (instruction),
    .data_mem_data (data_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a load and let the combinational path settle.
  task automatic drive_load(input logic [31:0] a, input logic [2:0] f3);
    mem_write   = 1'b0;
    mem_read    = 1'b1;
    alu_result  = a;
    instruction = {17'd0, f3, 12'h003};
    #1;
  endtask

  // Present a store away from the edge, hold it across one rising edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    mem_read    = 1'b0;
    mem_write   = 1'b1;
    alu_result  = a;
    rs2_data    = d;
    instruction = {17'd0, f3, 12'h023};
    @(posedge clk);
    #1;
    mem_write   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    drive_load(32'h0, 3'b010);
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_rst_lw0 got=%h exp=%h", data_mem_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_load(32'h0, 3'b010);
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_lw_0x0 got=%h exp=%h", data_mem_data, 32'h0);
    end
    drive_load(32'h3FC, 3'b010);
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_lw_0x3fc got=%h exp=%h", data_mem_data, 32'h0);
    end
    drive_load(32'h200, 3'b010);
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_lw_0x200 got=%h exp=%h", data_mem_data, 32'h0);
    end
  endtask

  task automatic test_byte;
    do_store(32'h0, 32'h000000A5, 3'b000);
    drive_load(32'h0, 3'b000);
    checks++;
    if (data_mem_data !== 32'hFFFFFFA5) begin
      errors++;
      $display("FAIL lb_0x0 got=%h exp=%h", data_mem_data, 32'hFFFFFFA5);
    end
    drive_load(32'h0, 3'b100);
    checks++;
    if (data_mem_data !== 32'h000000A5) begin
      errors++;
      $display("FAIL lbu_0x0 got=%h exp=%h", data_mem_data, 32'h000000A5);
    end
    // SB must not touch the neighbouring byte.
    drive_load(32'h0, 3'b010);
    checks++;
    if (data_mem_data !== 32'h000000A5) begin
      errors++;
      $display("FAIL sb_only_one_byte got=%h exp=%h", data_mem_data, 32'h000000A5);
    end
  endtask

  task automatic test_half;
    do_store(32'h4, 32'h0000ABCD, 3'b001);
    drive_load(32'h4, 3'b001);
    checks++;
    if (data_mem_data !== 32'hFFFFABCD) begin
      errors++;
      $display("FAIL lh_0x4 got=%h exp=%h", data_mem_data, 32'hFFFFABCD);
    end
    drive_load(32'h4, 3'b101);
    checks++;
    if (data_mem_data !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL lhu_0x4 got=%h exp=%h", data_mem_data, 32'h0000ABCD);
    end
  endtask

  task automatic test_word;
    do_store(32'h8, 32'h12345678, 3'b010);
    drive_load(32'h8, 3'b010);
    checks++;
    if (data_mem_data !== 32'h12345678) begin
      errors++;
      $display("FAIL lw_0x8 got=%h exp=%h", data_mem_data, 32'h12345678);
    end
    drive_load(32'h8, 3'b100);
    checks++;
    if (data_mem_data !== 32'h00000078) begin
      errors++;
      $display("FAIL lbu_0x8 got=%h exp=%h", data_mem_data, 32'h00000078);
    end
    drive_load(32'hB, 3'b100);
    checks++;
    if (data_mem_data !== 32'h00000012) begin
      errors++;
      $display("FAIL lbu_0xb got=%h exp=%h", data_mem_data, 32'h00000012);
    end
    drive_load(32'h9, 3'b001);
    checks++;
    if (data_mem_data !== 32'h00003456) begin
      errors++;
      $display("FAIL lh_0x9_misaligned got=%h exp=%h", data_mem_data, 32'h00003456);
    end
    // Upper address bits are ignored: 0x408 aliases 0x8.
    drive_load(32'h0000_0408, 3'b010);
    checks++;
    if (data_mem_data !== 32'h12345678) begin
      errors++;
      $display("FAIL lw_alias_0x408 got=%h exp=%h", data_mem_data, 32'h12345678);
    end
  endtask

  task automatic test_wrap;
    do_store(32'h3FE, 32'hDEADBEEF, 3'b010);
    drive_load(32'h3FE, 3'b010);
    checks++;
    if (data_mem_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_wrap_0x3fe got=%h exp=%h", data_mem_data, 32'hDEADBEEF);
    end
    drive_load(32'h0, 3'b100);
    checks++;
    if (data_mem_data !== 32'h000000AD) begin
      errors++;
      $display("FAIL lbu_wrap_0x0 got=%h exp=%h", data_mem_data, 32'h000000AD);
    end
  endtask

  task automatic test_read_disable;
    drive_load(32'h8, 3'b010);
    mem_read = 1'b0;
    #1;
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL read_disabled got=%h exp=%h", data_mem_data, 32'h0);
    end
  endtask

  task automatic test_invalid_funct3;
    do_store(32'h8, 32'hFFFFFFFF, 3'b011);
    drive_load(32'h8, 3'b010);
    checks++;
    if (data_mem_data !== 32'h12345678) begin
      errors++;
      $display("FAIL store_f3_011_no_write got=%h exp=%h", data_mem_data, 32'h12345678);
    end
    drive_load(32'h8, 3'b011);
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL load_f3_011 got=%h exp=%h", data_mem_data, 32'h0);
    end
    drive_load(32'h8, 3'b110);
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL load_f3_110 got=%h exp=%h", data_mem_data, 32'h0);
    end
  endtask

  task automatic test_read_during_write;
    @(negedge clk);
    mem_read    = 1'b1;
    mem_write   = 1'b1;
    alu_result  = 32'h20;
    rs2_data    = 32'hCAFEF00D;
    instruction = {17'd0, 3'b010, 12'h023};
    #1;
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL rdwr_pre_edge got=%h exp=%h", data_mem_data, 32'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (data_mem_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rdwr_post_edge got=%h exp=%h", data_mem_data, 32'hCAFEF00D);
    end
    mem_write = 1'b0;
  endtask

  task automatic test_reset_mid;
    drive_load(32'h8, 3'b010);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_lw_0x8 got=%h exp=%h", data_mem_data, 32'h0);
    end
    // Store held across an edge while reset is still asserted.
    mem_read    = 1'b0;
    mem_write   = 1'b1;
    alu_result  = 32'h10;
    rs2_data    = 32'h55AA55AA;
    instruction = {17'd0, 3'b010, 12'h023};
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_load(32'h10, 3'b010);
    checks++;
    if (data_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL store_during_reset got=%h exp=%h", data_mem_data, 32'h0);
    end
    do_store(32'h10, 32'h0BADF00D, 3'b010);
    drive_load(32'h10, 3'b010);
    checks++;
    if (data_mem_data !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL store_after_reset got=%h exp=%h", data_mem_data, 32'h0BADF00D);
    end
  endtask

  initial begin
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    rs2_data    = 32'h0;
    alu_result  = 32'h0;
    instruction = 32'h0;
    test_reset();
    test_byte();
    test_half();
    test_word();
    test_invalid_funct3();
    test_wrap();
    test_read_disable();
    test_read_during_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable data memory for the single-cycle RISC-V core. It sits after the ALU in the MEM stage: it takes the ALU-computed effective address, executes RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) selected by the instruction's funct3, and returns the extended load value to write-back. Stores are clocked; loads are combinational.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10, number of byte-address bits used; memory holds 2^ADDR_WIDTH bytes (default 1024).

Ports:
- `clk`  input  1  clock; the only clock, all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `mem_read`  input  1  load enable.
- `mem_write`  input  1  store enable.
- `rs2_data`  input  32  store data, taken from the low bits for SB/SH.
- `alu_result`  input  32  effective byte address.
- `instruction`  input  32  current instruction; funct3 = `instruction[14:12]`.
- `data_mem_data`  output  32  load result, already sign- or zero-extended.

## Operation
- Storage: array of 2^ADDR_WIDTH bytes, little-endian (lowest address holds the least significant byte).
- Address: `a = alu_result[ADDR_WIDTH-1:0]`; upper bits are ignored. Multi-byte accesses touch a, a+1, a+2, a+3, each taken modulo the depth, so accesses wrap around at the top of memory. No alignment check: misaligned accesses are performed byte-wise.
- Stores, when `mem_write`=1 on a rising edge:
  - funct3 000 (SB): mem[a] <= rs2_data[7:0].
  - funct3 001 (SH): writes 2 bytes from rs2_data[15:0].
  - funct3 010 (SW): writes 4 bytes from rs2_data[31:0].
  - Any other funct3: no write.
- Loads, when `mem_read`=1 (combinational):
  - 000 (LB): sign-extend mem[a].
  - 001 (LH): sign-extend the halfword at a.
  - 010 (LW): the word at a.
  - 100 (LBU): zero-extend the byte.
  - 101 (LHU): zero-extend the halfword.
  - Any other funct3: 0.
- `mem_read`=0: `data_mem_data` = 0.
- `mem_read` and `mem_write` both 1: the store commits at the edge. The output shows the pre-edge contents before the edge and the new contents after it.
- Reset: while `rst`=1, every byte is cleared to 0 immediately, without waiting for a clock edge, and writes are blocked. A store coincident with reset is discarded.

## Timing
- Store latency: 1 edge. Data is visible on the combinational read path right after the rising edge.
- Load latency: 0 cycles. The output is a pure function of the current inputs and memory contents.
- No handshake. Enables are sampled every cycle.
- Reset values: memory all 0; `data_mem_data` = 0, since the memory is zero and any load returns 0.
- Reset deasserting mid-cycle: normal writes resume at the next rising edge with `rst`=0.

## Structure
- Shared package (`riscv_pkg`) constants:
  - funct3 codes F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - XLEN=32.
- One natural sub-module, `load_extend`: takes funct3 and the 4 raw bytes read at a..a+3, and produces the extended 32-bit result.
- The top level holds the byte array, the write logic and the address wrap.

## Test plan
1. Reset, then LW at 0x0, 0x3FC and 0x200 -> 0x00000000.
2. SB rs2=0x000000A5 @0x0; then LB @0x0 -> 0xFFFFFFA5 and LBU @0x0 -> 0x000000A5.
3. SH rs2=0x0000ABCD @0x4; then LH @0x4 -> 0xFFFFABCD and LHU @0x4 -> 0x0000ABCD.
4. SW rs2=0x12345678 @0x8; then:
   - LW @0x8 -> 0x12345678.
   - LBU @0x8 -> 0x00000078; LBU @0xB -> 0x00000012.
   - LH @0x9 (misaligned) -> 0x00003456.
5. Edge cases:
   - SW 0xDEADBEEF @0x3FE (wraps): LW @0x3FE -> 0xDEADBEEF, and LBU @0x0 -> 0x000000AD.
   - mem_read=0 -> output 0x00000000.
   - funct3=011 store -> no memory change.
   - funct3=011 load -> 0x00000000.
6. Reset mid-operation:
   - After test 4, assert rst between clock edges. LW @0x8 must read 0 immediately, without waiting for an edge.
   - SW asserted together with rst -> no write.
